// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: scans a shadow bank of 4-bit codes onto one
// shared active-low segment bus, with a blank cycle between digit slots.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    hex_en,
  input  logic                    lz_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;

  logic [3:0]              cur_code;
  logic [NUM_DIGITS-1:0]   dp_vec;
  logic                    cur_dp;
  logic                    upper_zero;
  logic                    lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] s;
    s = 7'b1111111;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = hex ? 7'b0001000 : 7'b1111111;
      4'hB: s = hex ? 7'b0000011 : 7'b1111111;
      4'hC: s = hex ? 7'b1000110 : 7'b1111111;
      4'hD: s = hex ? 7'b0100001 : 7'b1111111;
      4'hE: s = hex ? 7'b0000110 : 7'b1111111;
      4'hF: s = hex ? 7'b0001110 : 7'b1111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_code = 4'(sh_data >> {idx, 2'b00});
    dp_vec   = sh_dp >> idx;
    cur_dp   = dp_vec[0];
  end

  // Walk from the most significant digit down; a digit is a leading zero when it and
  // everything above it is zero. Digit 0 always stays visible.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (sh_data[i*4 +: 4] == 4'd0);
      if (i == int'(idx) && i != 0) lz_blank = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      idx         <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      seg_n       <= 7'b1111111;
      dp_n        <= 1'b1;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp;
      end
      pcnt        <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
      frame_start <= 1'b0;
      if (pcnt == PLAST) begin
        idx   <= (idx == ILAST) ? '0 : idx + IW'(1);
        an_n  <= '1;
        seg_n <= 7'b1111111;
        dp_n  <= 1'b1;
      end else if (pcnt == '0) begin
        an_n        <= ~(NUM_DIGITS'(1) << idx);
        seg_n       <= (lz_en && lz_blank) ? 7'b1111111 : decode(cur_code, hex_en);
        dp_n        <= ~cur_dp;
        frame_start <= (idx == '0);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots) against an
// edge-counting reference model of the scan schedule.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        hex_en = 1'b0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: edges since reset release and the model's shadow bank
  int          edge_no = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  exp_seg = 7'b1111111;
  logic        exp_dp = 1'b1;
  logic [3:0]  exp_an = 4'b1111;
  logic        exp_fs = 1'b0;
  logic [6:0]  segtab [16];

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .load(load),
    .hex_en(hex_en), .lz_en(lz_en), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] ref_seg(input int digit, input logic hx, input logic lz);
    int code;
    code = (int'(m_data) >> (4 * digit)) % 16;
    if (lz && digit > 0 && (int'(m_data) >> (4 * digit)) == 0) return 7'b1111111;
    if (code > 9 && !hx) return 7'b1111111;
    return segtab[code];
  endfunction

  // Position within the frame is derived purely from the number of edges since release.
  task automatic modelEdge();
    int pos;
    int digit;
    pos   = edge_no % SD;
    digit = (edge_no / SD) % ND;
    exp_fs = 1'b0;
    if (pos == SD - 1) begin
      exp_an  = 4'b1111;
      exp_seg = 7'b1111111;
      exp_dp  = 1'b1;
    end else if (pos == 0) begin
      exp_an  = 4'b1111;
      exp_an[digit] = 1'b0;
      exp_seg = ref_seg(digit, hex_en, lz_en);
      exp_dp  = ~m_dp[digit];
      exp_fs  = (digit == 0);
    end
    if (load) begin
      m_data = data;
      m_dp   = dp;
    end
    edge_no++;
  endtask

  task automatic modelReset();
    edge_no = 0;
    m_data  = '0;
    m_dp    = '0;
    exp_seg = 7'b1111111;
    exp_dp  = 1'b1;
    exp_an  = 4'b1111;
    exp_fs  = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert ({seg_n, dp_n, an_n, frame_start} === {exp_seg, exp_dp, exp_an, exp_fs})
    else begin
      miscompares++;
      $error("[TB] FAIL %s edge=%0d: seg_n=%b dp_n=%b an_n=%b fs=%b, expected seg_n=%b dp_n=%b an_n=%b fs=%b",
             tag, edge_no, seg_n, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] dv, input logic [3:0] dpv,
                               input logic hx, input logic lz, input string tag);
    load   = ld;
    data   = dv;
    dp     = dpv;
    hex_en = hx;
    lz_en  = lz;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
    load = 1'b0;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, data, dp, hex_en, lz_en, tag);
  endtask

  // Spin until the next edge is the drive edge of a given digit.
  task automatic alignTo(input int digit, input string tag);
    for (int k = 0; k < ND * SD && edge_no % (ND * SD) != digit * SD; k++) runCycles(1, tag);
  endtask

  initial begin
    segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    #4;
    rst_n = 1'b1;
    runCycles(1, "first_edge");
    runCycles(ND * SD - 1, "reset_frame");

    alignTo(0, "align");
    applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0, "load_1234");
    runCycles(2 * ND * SD, "frame_1234");

    applyStimulus(1'b1, 16'hABCD, 4'b0000, 1'b1, 1'b0, "load_abcd");
    runCycles(2 * ND * SD, "hex_abcd");
    hex_en = 1'b0;
    runCycles(ND * SD + 2, "dec_abcd");

    applyStimulus(1'b1, 16'h0005, 4'b0000, 1'b0, 1'b1, "lz_0005");
    runCycles(2 * ND * SD, "lz_0005");
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b0, 1'b1, "lz_0000");
    runCycles(2 * ND * SD, "lz_0000");
    applyStimulus(1'b1, 16'h0105, 4'b1000, 1'b0, 1'b1, "lz_0105");
    runCycles(2 * ND * SD, "lz_0105");

    alignTo(2, "align");
    applyStimulus(1'b1, 16'h9876, 4'b0001, 1'b0, 1'b0, "load_on_drive");
    runCycles(ND * SD + 4, "after_drive_load");

    for (int k = 0; k < 300; k++)
      applyStimulus(($urandom % 6) == 0, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    "random");

    alignTo(1, "align");
    applyStimulus(1'b1, 16'h4321, 4'b1111, 1'b1, 1'b0, "pre_reset");
    runCycles(1, "pre_reset");
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    checkOutput("reset_held");
    #3;
    rst_n = 1'b1;
    runCycles(2 * ND * SD, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
